// File: rtl/counter_event_monitor_if.sv
// Event record stream from counter_event_monitor to its consumer.
// First-word fall-through valid/ready handshake carrying {type, prev_q, new_q}.
interface counter_event_monitor_if #(
  parameter int WIDTH = 4
);
  localparam int REC_W = 2 + 2 * WIDTH;

  logic             ev_valid;
  logic             ev_ready;
  logic [REC_W-1:0] ev_data;

  modport master (output ev_valid, output ev_data, input  ev_ready);
  modport slave  (input  ev_valid, input  ev_data, output ev_ready);
endinterface

// File: rtl/counter_event_monitor.sv
// Watches a counter's Q output, classifies each step and queues wrap/jump
// events in a small FWFT FIFO, with saturating per-type event counters.
module counter_event_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         Q,
  input  logic                     clear,
  counter_event_monitor_if.master  ev,
  output logic [CNT_W-1:0]         wrap_up_cnt,
  output logic [CNT_W-1:0]         wrap_dn_cnt,
  output logic [CNT_W-1:0]         jump_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int REC_W = 2 + 2 * WIDTH;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_WRAP_UP = 2'b01;
  localparam logic [1:0] EV_WRAP_DN = 2'b10;
  localparam logic [1:0] EV_JUMP    = 2'b11;

  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [LW-1:0]    LVL_MAX = LW'(DEPTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] wrap_up_cnt_q, wrap_up_cnt_d;
  logic [CNT_W-1:0] wrap_dn_cnt_q, wrap_dn_cnt_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] prev_inc, prev_dec;
  logic [1:0]       ev_type;
  logic [REC_W-1:0] ev_rec;
  logic             has_event, full, push, pop;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    prev_inc = prev_q + Q_ONE;
    prev_dec = prev_q - Q_ONE;
    ev_type  = EV_NONE;
    if (state_q == ST_RUN) begin
      // Unknown bits in Q fail every equality and land in the JUMP branch.
      if (Q == prev_q)        ev_type = EV_NONE;
      else if (Q == prev_inc) ev_type = (prev_q == '1) ? EV_WRAP_UP : EV_NONE;
      else if (Q == prev_dec) ev_type = (prev_q == '0) ? EV_WRAP_DN : EV_NONE;
      else                    ev_type = EV_JUMP;
    end
    ev_rec    = {ev_type, prev_q, Q};
    has_event = (ev_type != EV_NONE) && !clear;
  end

  assign full = (level_q == LVL_MAX);
  assign pop  = ev.ev_valid && ev.ev_ready && !clear;
  assign push = has_event && (!full || pop);

  always_comb begin
    state_d       = ST_RUN;
    prev_d        = Q;
    wrap_up_cnt_d = wrap_up_cnt_q;
    wrap_dn_cnt_d = wrap_dn_cnt_q;
    jump_cnt_d    = jump_cnt_q;
    overflow_d    = overflow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    if (clear) begin
      wrap_up_cnt_d = '0;
      wrap_dn_cnt_d = '0;
      jump_cnt_d    = '0;
      overflow_d    = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
    end else begin
      // Counters track every classified event, including dropped ones.
      case (ev_type)
        EV_WRAP_UP: if (wrap_up_cnt_q != '1) wrap_up_cnt_d = wrap_up_cnt_q + CNT_ONE;
        EV_WRAP_DN: if (wrap_dn_cnt_q != '1) wrap_dn_cnt_d = wrap_dn_cnt_q + CNT_ONE;
        EV_JUMP:    if (jump_cnt_q    != '1) jump_cnt_d    = jump_cnt_q    + CNT_ONE;
        default: ;
      endcase
      if (has_event && !push) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_PRIME;
      prev_q        <= '0;
      wrap_up_cnt_q <= '0;
      wrap_dn_cnt_q <= '0;
      jump_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      wrap_up_cnt_q <= wrap_up_cnt_d;
      wrap_dn_cnt_q <= wrap_dn_cnt_d;
      jump_cnt_q    <= jump_cnt_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
    end
  end

  // NOTE: the record storage is deliberately not reset; level_q gates every
  // read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_rec;
  end

  assign ev.ev_valid = (level_q != '0);
  assign ev.ev_data  = ev.ev_valid ? mem_q[rd_ptr_q] : '0;
  assign wrap_up_cnt = wrap_up_cnt_q;
  assign wrap_dn_cnt = wrap_dn_cnt_q;
  assign jump_cnt    = jump_cnt_q;
  assign overflow    = overflow_q;
  assign level       = level_q;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Scoreboard bench for counter_event_monitor: a reference model predicts
// records and status per cycle; a negedge monitor compares popped records.
module tb_counter_event_monitor;

  localparam int W     = 4;
  localparam int D     = 4;
  localparam int CW    = 8;
  localparam int REC_W = 2 + 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [W-1:0]  q_in;
  logic [CW-1:0] wrap_up_cnt, wrap_dn_cnt, jump_cnt;
  logic          overflow;
  logic [$clog2(D):0] level;

  counter_event_monitor_if #(.WIDTH(W)) ifc ();

  counter_event_monitor #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .Q           (q_in),
    .clear       (clear),
    .ev          (ifc.master),
    .wrap_up_cnt (wrap_up_cnt),
    .wrap_dn_cnt (wrap_dn_cnt),
    .jump_cnt    (jump_cnt),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  logic [REC_W-1:0] exp_q[$];
  int               m_level, m_up, m_dn, m_jump;
  bit               m_ovf, m_primed;
  logic [W-1:0]     m_prev;

  int               rx_cnt = 0;
  logic [REC_W-1:0] last_rx = '0;
  logic [REC_W-1:0] sb_rec;

  function automatic logic [1:0] classify(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [W-1:0] inc, dec;
    inc = p + 4'd1;
    dec = p - 4'd1;
    if (q == p)   return 2'b00;
    if (q == inc) return (p == 4'hF) ? 2'b01 : 2'b00;
    if (q == dec) return (p == 4'h0) ? 2'b10 : 2'b00;
    return 2'b11;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Drive one cycle's inputs, predict the next edge, then check status after it.
  task automatic cycle(input logic [W-1:0] qv, input bit rdy, input bit clr, input bit rs);
    logic [1:0] et;
    bit         do_pop, do_push;
    q_in = qv; ifc.ev_ready = rdy; clear = clr; rst = rs;
    if (rs) begin
      m_level = 0; exp_q.delete(); m_primed = 0; m_prev = '0;
      m_up = 0; m_dn = 0; m_jump = 0; m_ovf = 0;
    end else begin
      et = m_primed ? classify(m_prev, qv) : 2'b00;
      if (clr) begin
        m_level = 0; exp_q.delete(); m_up = 0; m_dn = 0; m_jump = 0; m_ovf = 0;
      end else begin
        do_pop  = (m_level > 0) && rdy;
        do_push = 1'b0;
        if (et != 2'b00) begin
          do_push = (m_level < D) || do_pop;
          if (do_push) exp_q.push_back({et, m_prev, qv});
          else m_ovf = 1'b1;
          case (et)
            2'b01:   m_up   = sat_inc(m_up);
            2'b10:   m_dn   = sat_inc(m_dn);
            default: m_jump = sat_inc(m_jump);
          endcase
        end
        m_level = m_level + int'(do_push) - int'(do_pop);
      end
      m_prev = qv; m_primed = 1'b1;
    end
    @(posedge clk); #1;
    check("level",       level,         m_level);
    check("ev_valid",    ifc.ev_valid,  m_level > 0);
    check("wrap_up_cnt", wrap_up_cnt,   m_up);
    check("wrap_dn_cnt", wrap_dn_cnt,   m_dn);
    check("jump_cnt",    jump_cnt,      m_jump);
    check("overflow",    overflow,      m_ovf);
    if (m_level == 0) check("ev_data_idle", ifc.ev_data, '0);
  endtask

  // Handshakes are stable from here until the next posedge, where the pop happens.
  always @(negedge clk) begin
    if (!rst && !clear && ifc.ev_valid && ifc.ev_ready) begin
      if (exp_q.size() == 0) check("sb_extra_rec", 32'(exp_q.size()), 32'd1);
      else begin
        sb_rec = exp_q.pop_front();
        check("ev_data", ifc.ev_data, sb_rec);
        rx_cnt++;
        last_rx = ifc.ev_data;
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; clear = 1'b0; q_in = '0; ifc.ev_ready = 1'b0;
    m_level = 0; m_up = 0; m_dn = 0; m_jump = 0; m_ovf = 0; m_primed = 0; m_prev = '0;

    cycle(4'd0, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b0, 1'b1);
    check("rst_ev_valid", ifc.ev_valid, 1'b0);
    check("rst_level",    level,        '0);

    // Wrap up: prime on 0, step 1..15, then 0
    base = rx_cnt;
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) cycle(W'(i), 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    check("wrap_up_recs", rx_cnt - base, 1);
    check("wrap_up_rec",  last_rx,       {2'b01, 4'hF, 4'h0});
    check("wrap_up_cnt1", wrap_up_cnt,   8'd1);

    // Wrap down: clear on 2 so the repositioning is not an event
    base = rx_cnt;
    cycle(4'd2, 1'b1, 1'b1, 1'b0);
    cycle(4'd1, 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    cycle(4'd15, 1'b1, 1'b0, 1'b0);
    cycle(4'd14, 1'b1, 1'b0, 1'b0);
    cycle(4'd14, 1'b1, 1'b0, 1'b0);
    check("wrap_dn_recs", rx_cnt - base, 1);
    check("wrap_dn_rec",  last_rx,       {2'b10, 4'h0, 4'hF});
    check("wrap_dn_cnt1", wrap_dn_cnt,   8'd1);

    // Load jumps with holds in between
    base = rx_cnt;
    cycle(4'd3, 1'b1, 1'b1, 1'b0);
    cycle(4'd5, 1'b1, 1'b0, 1'b0);
    cycle(4'd5, 1'b1, 1'b0, 1'b0);
    cycle(4'd5, 1'b1, 1'b0, 1'b0);
    cycle(4'd12, 1'b1, 1'b0, 1'b0);
    cycle(4'd12, 1'b1, 1'b0, 1'b0);
    check("jump_recs", rx_cnt - base, 2);
    check("jump_rec2", last_rx,       {2'b11, 4'd5, 4'd12});
    check("jump_cnt2", jump_cnt,      8'd2);

    // Backpressure: 5 jumps into a 4-deep FIFO
    base = rx_cnt;
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'd5, 1'b0, 1'b0, 1'b0);
    cycle(4'd10, 1'b0, 1'b0, 1'b0);
    cycle(4'd3, 1'b0, 1'b0, 1'b0);
    cycle(4'd8, 1'b0, 1'b0, 1'b0);
    cycle(4'd13, 1'b0, 1'b0, 1'b0);
    cycle(4'd13, 1'b0, 1'b0, 1'b0);
    check("bp_level",    level,    3'd4);
    check("bp_overflow", overflow, 1'b1);
    check("bp_jump_cnt", jump_cnt, 8'd5);
    for (int i = 0; i < 6; i++) cycle(4'd13, 1'b1, 1'b0, 1'b0);
    check("bp_drained",  rx_cnt - base, 4);
    check("bp_last_rec", last_rx,       {2'b11, 4'd3, 4'd8});
    check("bp_ovf_held", overflow,      1'b1);

    // Full FIFO with simultaneous push and pop
    base = rx_cnt;
    cycle(4'd13, 1'b0, 1'b1, 1'b0);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
    cycle(4'd7, 1'b0, 1'b0, 1'b0);
    cycle(4'd12, 1'b0, 1'b0, 1'b0);
    cycle(4'd1, 1'b0, 1'b0, 1'b0);
    cycle(4'd6, 1'b1, 1'b0, 1'b0);
    check("pp_level",    level,    3'd4);
    check("pp_overflow", overflow, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'd6, 1'b1, 1'b0, 1'b0);
    check("pp_drained",  rx_cnt - base, 5);
    check("pp_last_rec", last_rx,       {2'b11, 4'd1, 4'd6});

    // Reset mid-stream with two records queued
    cycle(4'd1, 1'b0, 1'b1, 1'b0);
    cycle(4'd9, 1'b0, 1'b0, 1'b0);
    cycle(4'd4, 1'b0, 1'b0, 1'b0);
    check("mid_level", level, 3'd2);
    cycle(4'd4, 1'b1, 1'b0, 1'b1);
    check("mid_rst_valid", ifc.ev_valid, 1'b0);
    check("mid_rst_jump",  jump_cnt,     8'd0);
    base = rx_cnt;
    cycle(4'd15, 1'b1, 1'b0, 1'b0);
    check("prime_no_ev", level, 3'd0);
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b1, 1'b0, 1'b0);
    check("post_rst_recs", rx_cnt - base, 1);
    check("post_rst_rec",  last_rx,       {2'b01, 4'hF, 4'h0});
    check("post_rst_up",   wrap_up_cnt,   8'd1);
    check("sb_empty",      exp_q.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_event_monitor.md
Name: counter_event_monitor

Overview:
- Downstream consumer of the 4-bit up/down counter's Q output.
- Samples Q every clock and classifies each transition as hold, increment, decrement or jump.
- Pushes wrap-up, wrap-down and jump events as records into a small FIFO drained through a valid/ready interface.
- Keeps saturating per-type event counters and a sticky overflow flag for scoreboards and debug logic.

Parameters:
- WIDTH, 4, counter width (bit width of Q).
- DEPTH, 4, event FIFO depth in records; power of two, minimum 2.
- CNT_W, 8, width of each saturating event counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- Q  input  WIDTH  counter value, sampled each posedge.
- clear  input  1  synchronous clear of counters, overflow flag and FIFO; no reset of the priming state.
- ev_valid  output  1  head FIFO record is available.
- ev_ready  input  1  consumer accepts the head record when ev_valid=1.
- ev_data  output  2+2*WIDTH  record {type[1:0], prev_q, new_q}; type 01=WRAP_UP, 10=WRAP_DN, 11=JUMP.
- wrap_up_cnt  output  CNT_W  saturating count of WRAP_UP events.
- wrap_dn_cnt  output  CNT_W  saturating count of WRAP_DN events.
- jump_cnt  output  CNT_W  saturating count of JUMP events.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge): ev_valid=0, ev_data=0, all counters=0, overflow=0, level=0, prev_q=0, state=PRIME.
- State machine has two states:
  - PRIME: the first posedge after reset stores Q into prev_q, emits nothing, then moves to RUN.
  - RUN: each posedge compares Q against prev_q, then sets prev_q<=Q.
- Classification in RUN, with all arithmetic modulo 2^WIDTH:
  - Q==prev_q: HOLD, no event.
  - Q==prev_q+1: INC. It is a WRAP_UP event only if prev_q==2^WIDTH-1 (15->0).
  - Q==prev_q-1: DEC. It is a WRAP_DN event only if prev_q==0 (0->15).
  - Any other change: JUMP event. A load to a different value counts as a jump; a load to the same value is a HOLD.
  - Non-wrapping INC and DEC produce no event.
- Latency: an event classified at posedge N appears in the FIFO and level at N+1. ev_valid asserts at N+1 if the FIFO was empty.
- FIFO and handshake:
  - FIFO is first-word fall-through; ev_data always shows the head record while ev_valid=1.
  - A pop occurs when ev_valid && ev_ready at a posedge.
  - ev_data is held stable while ev_valid=1 and ev_ready=0.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - When full, a push succeeds only if a pop happens in the same cycle.
  - If full with no pop: the event is dropped and overflow<=1 (sticky until rst or clear). The event counters still increment.
  - With ev_ready=0 and FIFO empty, ev_valid stays 0.
- Counters: each increments by 1 per event of its type. Each saturates at 2^CNT_W-1 and never wraps.
- clear=1 at posedge:
  - Counters, overflow and FIFO go to 0 (level=0, ev_valid=0).
  - prev_q still updates and the state stays RUN.
  - An event classified in the same cycle is discarded: not pushed and not counted.
- rst asserted mid-operation: immediate return to reset values and PRIME at that posedge. In-flight records are lost.
- Q containing X or Z in RUN: classified as JUMP. The bench must not drive X/Z into the monitor except in the dedicated X test.

Test Plan:
- Reset, then Q stepping 0,1,2…15,0 with ev_ready=1:
  - exactly one record, {01,4'hF,4'h0}, with ev_valid high one cycle after the 15->0 sample;
  - wrap_up_cnt=1, others 0.
- Q stepping 2,1,0,15,14:
  - one record {10,4'h0,4'hF};
  - wrap_dn_cnt=1.
- Load jump, Q 3->5 (hold 5 for 3 cycles), then 5->12:
  - two records, {11,3,5} then {11,5,12};
  - the holds give no records;
  - jump_cnt=2.
- Backpressure with ev_ready=0 and 5 jumps at DEPTH=4:
  - level=4, overflow=1, jump_cnt=5;
  - after ev_ready=1, exactly 4 records drain in order and the 5th jump is absent;
  - overflow stays 1 until clear.
- Simultaneous push/pop when full: a jump while ev_ready=1 → level stays 4, overflow stays 0.
- rst for 1 cycle mid-stream with 2 records queued:
  - ev_valid=0 and counters=0 next cycle;
  - the first post-reset sample emits nothing (PRIME);
  - 15->0 afterwards is still detected.
